strait_psum_drain: RTL and testbench

- Downstream of the STRAIT top level, on the normal-mode result path.
- After a compute pass, walks every accumulator row by driving the accumulator read address (the top-level rd_addr input).
- Absorbs the accumulator's fixed read latency and streams each row to the host over a valid/ready interface with full backpressure.
- Signals pass completion with a one-cycle done pulse.

---
 rtl/strait_psum_drain.sv | 203 ++++++++++++++++++++
 tb/tb_strait_psum_drain.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/strait_psum_drain.sv
// strait_psum_drain: walks every accumulator row after a compute pass and
// streams the rows to the host over a valid/ready interface with full
// backpressure. It absorbs the fixed accumulator read latency with a skid FIFO.
//
// Optional feature: define STRAIT_DRAIN_RELU_EN to clamp negative lanes to
// zero as rows enter the FIFO. When it is undefined, lanes pass bit-exact.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start (ignored while test_mode is high)
// ISSUE  | issuing row reads whenever the FIFO has credit
// DRAIN  | all reads issued; waiting for the last beat to transfer
// DONE   | one-cycle done pulse, then back to IDLE

module strait_psum_drain #(
   parameter int SYSTOLIC_SIZE     = 8,
   parameter int PARTIAL_SUM_WIDTH = 19,
   parameter int ADDR_WIDTH        = 3,
   parameter int RD_LATENCY        = 1
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         start,
   input  logic                                         test_mode,
   output logic [ADDR_WIDTH-1:0]                        rd_addr,
   input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0]   psum_in_flat,
   output logic                                         out_valid,
   input  logic                                         out_ready,
   output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0]   out_data,
   output logic [ADDR_WIDTH-1:0]                        out_addr,
   output logic                                         out_last,
   output logic                                         busy,
   output logic                                         done
);

   localparam int DW    = SYSTOLIC_SIZE * PARTIAL_SUM_WIDTH;
   localparam int PSW   = PARTIAL_SUM_WIDTH;
   localparam int DEPTH = RD_LATENCY + 1;
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] issue_addr_q, issue_addr_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

   logic [RD_LATENCY-1:0] tag_q;
   logic [ADDR_WIDTH-1:0] tag_addr_q [RD_LATENCY];

   logic [ADDR_WIDTH-1:0] fifo_addr_q [DEPTH];
   logic [DW-1:0]         fifo_data_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]         occ_q;

   logic                  abort;
   logic                  push;
   logic                  pop;
   logic                  issue;
   logic                  credit;
   logic                  drain_empty;
   logic [CW-1:0]         inflight_cnt;
   logic [CW:0]           need;
   logic [DW-1:0]         wr_data;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign abort     = test_mode && (state_q != ST_IDLE);
   assign out_valid = (occ_q != '0);
   assign pop       = out_valid && out_ready;
   assign push      = tag_q[RD_LATENCY-1] && !abort;

   // Credit: occupancy after this cycle's pop plus reads still in flight.
   // Counting the pop keeps full throughput without risking overflow, since
   // every issued read already has a reserved FIFO slot.
   always_comb begin
      inflight_cnt = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight_cnt = inflight_cnt + CW'(tag_q[i]);
      end
      need        = {1'b0, occ_q} + {1'b0, inflight_cnt} - (CW+1)'(pop);
      credit      = need < (CW+1)'(DEPTH);
      issue       = (state_q == ST_ISSUE) && credit && !abort;
      drain_empty = (inflight_cnt == '0) &&
                    ((occ_q == '0) || ((occ_q == CW'(1)) && pop));
   end

   // Lane conditioning on the way into the FIFO
   always_comb begin
      wr_data = psum_in_flat;
`ifdef STRAIT_DRAIN_RELU_EN
      for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
         if (psum_in_flat[i*PSW + PSW - 1]) begin
            wr_data[i*PSW +: PSW] = '0;
         end
      end
`endif
   end

   // FSM next-state and read-address sequencing
   always_comb begin
      state_d      = state_q;
      issue_addr_d = issue_addr_q;
      rd_addr_d    = rd_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !test_mode) begin
               state_d      = ST_ISSUE;
               issue_addr_d = '0;
            end
         end
         ST_ISSUE: begin
            if (issue) begin
               rd_addr_d    = issue_addr_q;
               issue_addr_d = issue_addr_q + 1'b1;
               if (issue_addr_q == LAST_ADDR) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_empty) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (abort) begin
         state_d      = ST_IDLE;
         issue_addr_d = '0;
      end
   end

   // FSM and address registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         issue_addr_q <= '0;
         rd_addr_q    <= '0;
      end else begin
         state_q      <= state_d;
         issue_addr_q <= issue_addr_d;
         rd_addr_q    <= rd_addr_d;
      end
   end

   // Read-latency valid tags; cleared on abort so late returns are dropped
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         tag_q <= '0;
      end else begin
         tag_q[0] <= issue;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // Issued addresses travel alongside their tags
   always_ff @(posedge clk) begin
      tag_addr_q[0] <= issue_addr_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
         tag_addr_q[i] <= tag_addr_q[i-1];
      end
   end

   // Skid FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         occ_q <= occ_q + CW'(push) - CW'(pop);
      end
   end

   // Skid FIFO storage
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= tag_addr_q[RD_LATENCY-1];
         fifo_data_q[wr_ptr_q] <= wr_data;
      end
   end

   // Head is masked when empty so stale entries never leak after a flush
   assign out_data = out_valid ? fifo_data_q[rd_ptr_q] : '0;
   assign out_addr = out_valid ? fifo_addr_q[rd_ptr_q] : '0;
   assign out_last = out_valid && (fifo_addr_q[rd_ptr_q] == LAST_ADDR);
   assign rd_addr  = rd_addr_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_strait_psum_drain.sv
// Directed bench for strait_psum_drain: one instance at read latency 1 for
// pass/abort/reset/start-filter/ReLU sequences, one at latency 3 for
// backpressure.

module tb_strait_psum_drain;

   localparam int DW = 8 * 19;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   logic neg_mode = 1'b0;

   // u1: RD_LATENCY = 1
   logic          rst1, start1, tm1, ready1;
   logic [2:0]    rd_addr1, out_addr1;
   logic [DW-1:0] psum1, out_data1;
   logic          out_valid1, out_last1, busy1, done1;

   // u3: RD_LATENCY = 3
   logic          rst3, start3, tm3, ready3;
   logic [2:0]    rd_addr3, out_addr3;
   logic [DW-1:0] psum3, out_data3;
   logic          out_valid3, out_last3, busy3, done3;
   logic [2:0]    p3a, p3b;

   strait_psum_drain #(.RD_LATENCY(1)) u1 (
      .clk(clk), .rst(rst1), .start(start1), .test_mode(tm1),
      .rd_addr(rd_addr1), .psum_in_flat(psum1),
      .out_valid(out_valid1), .out_ready(ready1), .out_data(out_data1),
      .out_addr(out_addr1), .out_last(out_last1), .busy(busy1), .done(done1)
   );

   strait_psum_drain #(.RD_LATENCY(3)) u3 (
      .clk(clk), .rst(rst3), .start(start3), .test_mode(tm3),
      .rd_addr(rd_addr3), .psum_in_flat(psum3),
      .out_valid(out_valid3), .out_ready(ready3), .out_data(out_data3),
      .out_addr(out_addr3), .out_last(out_last3), .busy(busy3), .done(done3)
   );

   // Accumulator model: row r, lane i = 16*r + i (lanes 0/1 replaced in neg_mode)
   function automatic logic [DW-1:0] acc_row(input logic [2:0] r, input logic neg);
      logic [DW-1:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) v[i*19 +: 19] = 19'(16 * int'(r) + i);
      if (neg) begin
         v[18:0]  = 19'h7FFFF;
         v[37:19] = 19'd5;
      end
      return v;
   endfunction

   function automatic logic [DW-1:0] exp_row(input logic [2:0] r, input logic neg);
      logic [DW-1:0] v;
      v = acc_row(r, neg);
`ifdef STRAIT_DRAIN_RELU_EN
      if (neg) v[18:0] = 19'd0;
`endif
      return v;
   endfunction

   assign psum1 = acc_row(rd_addr1, neg_mode);

   always @(posedge clk) begin
      p3a <= rd_addr3;
      p3b <= p3a;
   end
   assign psum3 = acc_row(p3b, 1'b0);

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   // Full pass on u1 with out_ready=1; optionally pulses start while busy
   task automatic run_pass1(input logic poke_start);
      logic [18:0] exp_l0;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      chk("busy_after_start", busy1, 1);
      chk("valid_lat0", out_valid1, 0);
      @(negedge clk);
      chk("valid_lat1", out_valid1, 0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("beat_valid", out_valid1, 1);
         chk("beat_addr", out_addr1, k);
         chk("beat_data", out_data1, exp_row(3'(k), neg_mode));
         chk("beat_last", out_last1, (k == 7));
         chk("beat_nodone", done1, 0);
         if (neg_mode && k == 0) begin
`ifdef STRAIT_DRAIN_RELU_EN
            exp_l0 = 19'd0;
`else
            exp_l0 = 19'h7FFFF;
`endif
            chk("relu_lane0", out_data1[18:0], exp_l0);
            chk("relu_lane1", out_data1[37:19], 19'd5);
         end
         if (poke_start && k == 2) start1 = 1'b1;
         if (k == 3) start1 = 1'b0;
      end
      @(negedge clk);
      chk("done_pulse", done1, 1);
      chk("done_busy", busy1, 1);
      chk("done_novalid", out_valid1, 0);
      @(negedge clk);
      chk("done_fall", done1, 0);
      chk("busy_fall", busy1, 0);
      repeat (4) begin
         @(negedge clk);
         chk("idle_novalid", out_valid1, 0);
         chk("idle_nobusy", busy1, 0);
      end
   endtask

   initial begin
      int beats;
      int dones;
      logic held_v;
      logic [DW-1:0] held_d;
      logic [2:0] held_a;
      logic [3:0] pat;

      rst1 = 1'b1; start1 = 1'b0; tm1 = 1'b0; ready1 = 1'b1;
      rst3 = 1'b1; start3 = 1'b0; tm3 = 1'b0; ready3 = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_rd_addr", rd_addr1, 0);
      chk("rst_valid", out_valid1, 0);
      chk("rst_data", out_data1, 0);
      chk("rst_addr", out_addr1, 0);
      chk("rst_last", out_last1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst3_valid", out_valid3, 0);
      chk("rst3_busy", busy3, 0);
      rst1 = 1'b0; rst3 = 1'b0;
      @(negedge clk);

      // Single pass with an ignored start pulse mid-pass
      run_pass1(1'b1);

      // Start with test_mode high is ignored
      tm1 = 1'b1; start1 = 1'b1;
      @(negedge clk);
      tm1 = 1'b0; start1 = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("tm_start_busy", busy1, 0);
         chk("tm_start_valid", out_valid1, 0);
      end

      // Abort after the third transfer
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_pre_addr", out_addr1, 3);
      chk("abort_pre_valid", out_valid1, 1);
      tm1 = 1'b1; ready1 = 1'b0;
      @(negedge clk);
      chk("abort_valid", out_valid1, 0);
      chk("abort_busy", busy1, 0);
      chk("abort_done", done1, 0);
      tm1 = 1'b0; ready1 = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("abort_quiet_valid", out_valid1, 0);
         chk("abort_quiet_done", done1, 0);
      end
      run_pass1(1'b0);

      // Reset during DRAIN
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      repeat (8) @(negedge clk);
      chk("drain_busy", busy1, 1);
      rst1 = 1'b1;
      @(negedge clk);
      chk("mrst_rd_addr", rd_addr1, 0);
      chk("mrst_valid", out_valid1, 0);
      chk("mrst_data", out_data1, 0);
      chk("mrst_addr", out_addr1, 0);
      chk("mrst_last", out_last1, 0);
      chk("mrst_busy", busy1, 0);
      chk("mrst_done", done1, 0);
      rst1 = 1'b0;
      run_pass1(1'b0);

      // Negative lanes
      neg_mode = 1'b1;
      run_pass1(1'b0);
      neg_mode = 1'b0;

      // Backpressure on the latency-3 instance, ready pattern 1,0,0,1
      pat = 4'b1001;
      beats = 0; dones = 0; held_v = 1'b0; held_d = '0; held_a = '0;
      @(negedge clk); start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      for (int cyc = 0; cyc < 70; cyc++) begin
         @(negedge clk);
         if (held_v) begin
            chk("bp_hold_valid", out_valid3, 1);
            chk("bp_hold_data", out_data3, held_d);
            chk("bp_hold_addr", out_addr3, held_a);
         end
         chk("bp_occ_le4", (u3.occ_q <= 4), 1);
         if (done3) dones++;
         ready3 = pat[3 - (cyc % 4)];
         if (out_valid3 && ready3) begin
            chk("bp_addr", out_addr3, beats);
            chk("bp_data", out_data3, exp_row(3'(beats), 1'b0));
            chk("bp_last", out_last3, (beats == 7));
            beats++;
            held_v = 1'b0;
         end else begin
            held_v = out_valid3;
            held_d = out_data3;
            held_a = out_addr3;
         end
      end
      chk("bp_beats", beats, 8);
      chk("bp_dones", dones, 1);
      chk("bp_busy_end", busy3, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
